// File: rtl/button_conditioner.sv
// Pushbutton conditioner: two-flop synchronizer, debounce FSM,
// registered level, rise/fall pulses and a press-toggled flag.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_WIDTH       = 16
) (
    input  logic clk,
    input  logic asyncReset,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_rise,
    output logic btn_fall,
    output logic toggle_q
);

    typedef enum logic [1:0] {
        STABLE_LOW,
        WAIT_HIGH,
        STABLE_HIGH,
        WAIT_LOW
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LP_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] LP_ONE  = CNT_WIDTH'(1);

    logic                 r_sync1;
    logic                 r_sync2;
    state_t               r_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_level;
    logic                 r_rise;
    logic                 r_fall;
    logic                 r_toggle;

    state_t               w_state_nxt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic                 w_rise;
    logic                 w_fall;
    logic                 w_level_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_rise      = 1'b0;
        w_fall      = 1'b0;
        unique case (r_state)
            STABLE_LOW: begin
                if (r_sync2) begin
                    w_state_nxt = WAIT_HIGH;
                    w_cnt_nxt   = LP_ONE;
                end
            end
            WAIT_HIGH: begin
                if (!r_sync2) begin
                    w_state_nxt = STABLE_LOW;
                end else if (r_cnt == LP_LAST) begin
                    w_state_nxt = STABLE_HIGH;
                    w_rise      = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + LP_ONE;
                end
            end
            STABLE_HIGH: begin
                if (!r_sync2) begin
                    w_state_nxt = WAIT_LOW;
                    w_cnt_nxt   = LP_ONE;
                end
            end
            WAIT_LOW: begin
                if (r_sync2) begin
                    w_state_nxt = STABLE_HIGH;
                end else if (r_cnt == LP_LAST) begin
                    w_state_nxt = STABLE_LOW;
                    w_fall      = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + LP_ONE;
                end
            end
            default: begin
                w_state_nxt = STABLE_LOW;
            end
        endcase
        // Level follows the state being entered so it lines up with the pulses
        w_level_nxt = (w_state_nxt == STABLE_HIGH) || (w_state_nxt == WAIT_LOW);
    end

    always_ff @(posedge clk or posedge asyncReset) begin
        if (asyncReset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_state  <= STABLE_LOW;
            r_cnt    <= '0;
            r_level  <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_toggle <= 1'b0;
        end else begin
            r_sync1  <= btn_in;
            r_sync2  <= r_sync1;
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_level  <= w_level_nxt;
            r_rise   <= w_rise;
            r_fall   <= w_fall;
            if (w_rise) begin
                r_toggle <= ~r_toggle;
            end
        end
    end

    assign btn_level = r_level;
    assign btn_rise  = r_rise;
    assign btn_fall  = r_fall;
    assign toggle_q  = r_toggle;

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, number of consecutive identical synchronized samples required to accept a new level; legal range 2..65535.
REQ-002 Parameter CNT_WIDTH, default 16, width of the internal debounce counter; SHALL hold DEBOUNCE_CYCLES.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 asyncReset  input  1  reset, asynchronous, active-high.
REQ-005 btn_in  input  1  raw asynchronous pushbutton/switch level, may bounce.
REQ-006 btn_level  output  1  debounced level, registered; drives the D input of the downstream flop stage.
REQ-007 btn_rise  output  1  one-cycle pulse on accepted 0->1 transition, registered.
REQ-008 btn_fall  output  1  one-cycle pulse on accepted 1->0 transition, registered.
REQ-009 toggle_q  output  1  registered level that inverts on every btn_rise.

Function
REQ-010 btn_in SHALL pass through a two-flop synchronizer (sync1, sync2); only sync2 is used by downstream logic.
REQ-011 FSM states SHALL be STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW; btn_level = 1 exactly in STABLE_HIGH and WAIT_LOW.
REQ-012 STABLE_LOW: sync2=1 -> WAIT_HIGH with cnt=1; else stay, cnt=0.
REQ-013 WAIT_HIGH: sync2=0 -> STABLE_LOW, cnt=0, no pulse; sync2=1 and cnt=DEBOUNCE_CYCLES-1 -> STABLE_HIGH, cnt=0; otherwise cnt+1.
REQ-014 STABLE_HIGH: sync2=0 -> WAIT_LOW with cnt=1; else stay, cnt=0.
REQ-015 WAIT_LOW: sync2=1 -> STABLE_HIGH, cnt=0, no pulse; sync2=0 and cnt=DEBOUNCE_CYCLES-1 -> STABLE_LOW, cnt=0; otherwise cnt+1.
REQ-016 btn_rise SHALL be 1 for exactly the cycle following the edge of the WAIT_HIGH->STABLE_HIGH transition; btn_fall likewise for WAIT_LOW->STABLE_LOW.
REQ-017 btn_rise and btn_fall SHALL never be 1 in the same cycle; consecutive pulses of either kind SHALL be separated by at least DEBOUNCE_CYCLES cycles.
REQ-018 toggle_q SHALL invert on the same edge that sets btn_rise; btn_fall SHALL not affect it.
REQ-019 Latency: btn_in stable high set up before edge k -> btn_level, btn_rise, toggle change after edge k+1+DEBOUNCE_CYCLES (DEBOUNCE_CYCLES+2 edges); falling edge symmetric.
REQ-020 Any bounce shorter than DEBOUNCE_CYCLES consecutive synchronized samples SHALL produce no change on any output.
REQ-021 Counter SHALL never wrap; it never exceeds DEBOUNCE_CYCLES-1.

Reset
REQ-022 asyncReset=1 SHALL immediately, independent of clk, force sync1=0, sync2=0, cnt=0, state=STABLE_LOW, btn_level=0, btn_rise=0, btn_fall=0, toggle_q=0.
REQ-023 Reset asserted mid-debounce or mid-pulse SHALL abort the pulse; no pulse is generated for the interrupted transition.
REQ-024 After deassertion with btn_in held 1, outputs SHALL follow REQ-019 from the first edge after release (btn_rise pulses once, toggle_q -> 1).

Verification
REQ-025 Clean press, DEBOUNCE_CYCLES=4: btn_in 0->1 before edge 0, held -> btn_level=1 and btn_rise=1 after edge 5, btn_rise=0 after edge 6, toggle_q=1.
REQ-026 Bounce: btn_in 1 for 3 cycles, 0 for 2, 1 for 3, then 0 -> btn_level, btn_rise, toggle_q remain 0 throughout.
REQ-027 Press then release (each held 10 cycles) twice -> two btn_rise, two btn_fall pulses, toggle_q sequence 0->1->0, never rise and fall together.
REQ-028 asyncReset pulsed between clock edges during WAIT_HIGH at cnt=2 -> all outputs 0 immediately; no btn_rise until 6 edges after release with btn_in held 1.
REQ-029 DEBOUNCE_CYCLES=2 boundary: single-cycle btn_in glitch -> no output change; 2-cycle pulse -> btn_level high for exactly the debounced window, one rise, one fall.
